// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32 core.
// Sequences fetch, decode, execute, memory and writeback steps for the
// shared ALU / memory datapath. It also decodes the immediate-extender
// select and the ALU operation, and it stalls on the mem_ready handshake.
module multicycle_ctrl #(
    parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [2:0] immsrc,
    output logic       regwrite,
    output logic       retire,
    output logic       illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [1:0]  aluop_s;
    logic        pcwrite_s;
    logic        memwrite_s;
    logic        irwrite_s;
    logic        regwrite_s;
    logic        retire_s;
    logic        illegal_s;
    logic        adrsrc_s;
    logic [1:0]  resultsrc_s;
    logic [1:0]  alusrca_s;
    logic [1:0]  alusrcb_s;

    // State register, cleared to FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore control decode for every step of an instruction.
    always_comb begin
        next_s      = state_r;
        aluop_s     = 2'b00;
        pcwrite_s   = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        retire_s    = 1'b0;
        illegal_s   = 1'b0;
        adrsrc_s    = 1'b0;
        resultsrc_s = 2'b00;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        case (state_r)
            S_FETCH: begin
                // PC+4 computed on the ALU while the instruction is read.
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                irwrite_s   = mem_ready;
                pcwrite_s   = mem_ready;
                if (mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target OldPC+imm lands in ALUOut for BEQ.
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECR;
                    OP_I:         next_s = S_EXECI;
                    OP_BEQ:       next_s = S_BEQ;
                    OP_JAL:       next_s = S_JAL;
                    OP_LUI:       next_s = S_LUI;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            next_s = S_TRAP;
                        end else begin
                            next_s   = S_FETCH;
                            retire_s = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                if (op == OP_LW) begin
                    next_s = S_MEMREAD;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adrsrc_s = 1'b1;
                if (mem_ready) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
                retire_s    = 1'b1;
                next_s      = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays high until memory accepts the write.
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else begin
                    next_s   = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b00;
                aluop_s   = 2'b10;
                next_s    = S_ALUWB;
            end
            S_EXECI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluop_s   = 2'b10;
                next_s    = S_ALUWB;
            end
            S_LUI: begin
                alusrca_s = 2'b11;
                alusrcb_s = 2'b01;
                next_s    = S_ALUWB;
            end
            S_ALUWB: begin
                resultsrc_s = 2'b00;
                regwrite_s  = 1'b1;
                retire_s    = 1'b1;
                next_s      = S_FETCH;
            end
            S_BEQ: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b00;
                aluop_s   = 2'b01;
                pcwrite_s = zero;
                retire_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_JAL: begin
                // Jump target from ALUOut into PC; PC+4 computed for rd.
                alusrca_s = 2'b01;
                alusrcb_s = 2'b10;
                pcwrite_s = 1'b1;
                next_s    = S_ALUWB;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                next_s    = S_TRAP;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    // ALU operation from the FSM's aluop and the instruction's funct fields.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop_s)
            2'b00: alucontrol = ALU_ADD;
            2'b01: alucontrol = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] & funct7b5) begin
                            alucontrol = ALU_SUB;
                        end else begin
                            alucontrol = ALU_ADD;
                        end
                    end
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

    // Immediate format select, decoded from op in every state.
    always_comb begin
        immsrc = 3'b000;
        case (op)
            OP_LW, OP_I: immsrc = 3'b000;
            OP_SW:       immsrc = 3'b001;
            OP_BEQ:      immsrc = 3'b010;
            OP_JAL:      immsrc = 3'b011;
            OP_LUI:      immsrc = 3'b100;
            default:     immsrc = 3'b000;
        endcase
    end

    // Enables are held low for the whole time reset is asserted.
    always_comb begin
        adrsrc    = adrsrc_s;
        resultsrc = resultsrc_s;
        alusrca   = alusrca_s;
        alusrcb   = alusrcb_s;
        if (rst_n) begin
            pcwrite  = pcwrite_s;
            memwrite = memwrite_s;
            irwrite  = irwrite_s;
            regwrite = regwrite_s;
            retire   = retire_s;
            illegal  = illegal_s;
        end else begin
            pcwrite  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule
